dmem_arbiter: RTL
=================

# dmem_arbiter

Two-master arbiter and sequencer for the single-port data memory. It shares one memory port between the pipeline MEM stage (master A) and a secondary master such as a loader, debug port or DMA (master B). It grants at most one access per cycle, drives the memory's chip-select, write-enable, address and write-data, and returns registered read data to the winner. It sits between the MEM stage / secondary master and the data memory, which reads combinationally and writes on posedge.

## Interface
- `DATA_W`, 32, data and address width.
- `STARVE_MAX`, 4, consecutive denied cycles of B before B overrides A (fixed-priority mode only); range 1–15.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_req`, `a_we`  in  1  A access request / write qualifier.
- `a_addr`, `a_wdata`  in  DATA_W  A byte address / write data.
- `a_gnt`  out  1  A access performed this cycle (combinational).
- `a_rvalid`  out  1  A read data valid (registered).
- `a_rdata`  out  DATA_W  A read data (registered).
- `b_req`, `b_we`, `b_lock`  in  1  B request / write / hold-grant.
- `b_addr`, `b_wdata`  in  DATA_W  B byte address / write data.
- `b_gnt`, `b_rvalid`  out  1  as for A.
- `b_rdata`  out  DATA_W  as for A.
- `mem_ce`, `mem_we`  out  1  memory chip-select / write enable.
- `mem_addr`, `mem_wdata`  out  DATA_W  memory address / write data.
- `mem_rdata`  in  DATA_W  memory combinational read data.

## Operation
- Requester holds `req`, `we`, `addr`, `wdata` stable until it sees `gnt`=1.
- The access completes in the grant cycle; there are no wait states.
- `a_gnt` and `b_gnt` are never both 1.
- `mem_ce` = `a_gnt | b_gnt`.
- `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted master.
- When nothing is granted, `mem_ce`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Registered state:
  - `starve_cnt` (4 bits, saturating at `STARVE_MAX`);
  - `lock_q` (1 bit);
  - `last_b` (1 bit);
  - rvalid/rdata registers.
- Grant decision, in priority order:
  1. `lock_q`=1 and `b_req`=1: grant B.
  2. Only one master requests: grant it.
  3. Both request: policy per Configuration.
- Fixed priority:
  - On contention, grant A unless `starve_cnt` ≥ `STARVE_MAX`, then grant B.
  - `starve_cnt` increments each cycle with `b_req` & !`b_gnt`.
  - It clears on `b_gnt` or !`b_req`.
- Lock:
  - `lock_q` is set at posedge when `b_gnt` & `b_lock`.
  - It is cleared at posedge when !`b_req`, or when `b_gnt` & !`b_lock`.
  - While `lock_q` is set, A is stalled indefinitely.
- Read return:
  - At posedge, `x_rvalid` <= `x_gnt` & !`x_we`.
  - At posedge, `x_rdata` <= `mem_rdata` when granted read; otherwise it holds.

## Timing
- Reset: `a/b_rvalid`=0, `a/b_rdata`=0, `starve_cnt`=0, `lock_q`=0, `last_b`=1 (A preferred first).
- Reset gives `gnt`=0 and `mem_ce`=0 while `rst` is high.
- Grant is combinational, in the same cycle as the request.
- Write commits at the posedge ending the grant cycle.
- Read latency is 1: `rvalid` is high for exactly one cycle after the grant cycle.
- Throughput is one access per cycle; back-to-back grants to the same master are allowed.
- Write then read to the same address in consecutive cycles, any masters: the read returns the new data.
- Reset asserted mid-access: the pending `rvalid` is dropped, an uncommitted write is lost, and the lock is released.
- `b_lock` with no grant has no effect.
- `lock_q` does not override A when `b_req`=0.

## Configuration
- `DMEM_ARB_RR_EN` defined: contention is resolved round-robin.
  - Grant B if `last_b`=0, else grant A.
  - `last_b` <= `b_gnt` on any grant cycle.
  - `starve_cnt` and `STARVE_MAX` are unused and the counter is not built.
- Undefined: fixed priority with starvation override as above; `last_b` is not built.
- Lock behaviour is identical in both builds.

## Test plan
- Reset, then A writes 0x1234_5678 to 0x10 with `a_req`=1 `a_we`=1 → `a_gnt`=1 same cycle, `mem_ce`=1, `mem_we`=1. Next cycle A reads 0x10 → `a_rvalid`=1 with `a_rdata`=0x1234_5678 one cycle later.
- Fixed priority, `STARVE_MAX`=4, both requesting reads continuously → grants A,A,A,A,B,A,A,A,A,B; `b_rvalid` pulses once per 5 cycles.
- RR build, both requesting continuously from reset → grants A,B,A,B; `a_rvalid`/`b_rvalid` alternate starting one cycle later.
- B read with `b_lock`=1 for 3 cycles, then `b_lock`=0 with `b_req` held → B granted 4 consecutive cycles while `a_req`=1; A is granted in cycle 5.
- B write 0xDEAD_BEEF to 0x20 followed immediately by A read of 0x20 → `a_rdata`=0xDEAD_BEEF.
- Assert `rst` in the cycle after a granted read → `rvalid` is 0 and `lock_q` is 0; the first post-reset contention grants A in both builds.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (A) and a secondary master (B).
// Latency: grant and memory drive are combinational; read data and rvalid return one cycle after the grant.
// Backpressure: a losing master holds its request until it sees gnt; no wait states once granted.
// Build option: define DMEM_ARB_RR_EN for round-robin contention; otherwise fixed A priority with B starvation override.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [DATA_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // B keeps the port while lock_q is set and it is still requesting.
  logic lock_q;
  // Which master takes the port when both request and no lock is active.
  logic b_wins;

`ifdef DMEM_ARB_RR_EN
  logic last_b;

  assign b_wins = !last_b;

  // Remember who won the most recent grant; reset prefers A first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (a_gnt || b_gnt) begin
      last_b <= b_gnt;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  assign b_wins = (starve_cnt >= STARVE_LIM);

  // Count consecutive cycles B waits; saturates so the override stays armed until B wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (b_req && !b_gnt) begin
      if (starve_cnt < STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`endif

  // Grant decision: held lock first, then sole requester, then contention policy.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (lock_q && b_req) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        b_gnt = b_wins;
        a_gnt = !b_wins;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Steer the winner onto the memory port; an idle port is driven to all zeros.
  always_comb begin
    mem_ce    = a_gnt | b_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Lock tracks b_lock on each B grant and drops as soon as B stops requesting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (!b_req) begin
      lock_q <= 1'b0;
    end else if (b_gnt) begin
      lock_q <= b_lock;
    end
  end

  // Capture read data for A on a granted read; rdata holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      if (a_gnt && !a_we) begin
        a_rdata <= mem_rdata;
      end
    end
  end

  // Capture read data for B on a granted read; rdata holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      b_rvalid <= b_gnt && !b_we;
      if (b_gnt && !b_we) begin
        b_rdata <= mem_rdata;
      end
    end
  end

endmodule
